ref_block_packer: RTL and testbench

//  Upstream feeder for the interpolation input row shift register.

---
 rtl/ref_block_packer.sv | 158 +++++++++++++++
 tb/tb_ref_block_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_block_packer.sv
// Reference block packer: collects ROW_PIX pixels per row from a valid/ready
// stream and strobes ROWS packed rows per block into the row shift register.

module ref_block_packer_lane #(
  parameter int PIX_W = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             wr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] pix_d
);
  logic [PIX_W-1:0] pix_q;

  // pix_d exposes the post-write value so the final beat of a row lands in the same push
  always_comb pix_d = wr ? din : pix_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) pix_q <= '0;
    else          pix_q <= pix_d;
  end
endmodule

module ref_block_packer #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 15,
  parameter int ROWS    = 15
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [ROW_PIX*PIX_W-1:0] row_out,
  output logic                     row_load_L,
  output logic [3:0]               row_idx,
  output logic                     busy,
  output logic                     block_done
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PUSH, S_DONE} state_t;

  localparam logic [3:0] PIX_LAST = 4'(ROW_PIX - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  state_t                       state_q, state_d;
  logic [3:0]                   pix_cnt_q, pix_cnt_d;
  logic [3:0]                   row_cnt_q, row_cnt_d;
  logic                         pix_ready_q, pix_ready_d;
  logic [ROW_PIX*PIX_W-1:0]     row_out_q, row_out_d;
  logic                         row_load_L_q, row_load_L_d;
  logic [3:0]                   row_idx_q, row_idx_d;
  logic                         busy_q, busy_d;
  logic                         block_done_q, block_done_d;

  logic                         beat;
  logic [ROW_PIX-1:0]           lane_wr;
  logic [ROW_PIX-1:0][PIX_W-1:0] asm_row;

  // pix_ready_q is only ever high in FILL, so a beat implies FILL
  assign beat = pix_valid & pix_ready_q;

  for (genvar k = 0; k < ROW_PIX; k++) begin : g_lane
    assign lane_wr[k] = beat && (pix_cnt_q == 4'(k));
    ref_block_packer_lane #(.PIX_W(PIX_W)) u_lane (
      .clock   (clock),
      .reset_L (reset_L),
      .wr      (lane_wr[k]),
      .din     (pix_in),
      .pix_d   (asm_row[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    row_cnt_d    = row_cnt_q;
    pix_ready_d  = pix_ready_q;
    row_out_d    = row_out_q;
    row_load_L_d = 1'b1;
    row_idx_d    = row_idx_q;
    busy_d       = busy_q;
    block_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        pix_ready_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          state_d     = S_FILL;
          pix_cnt_d   = '0;
          row_cnt_d   = '0;
          pix_ready_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_FILL: begin
        if (beat) begin
          if (pix_cnt_q == PIX_LAST) begin
            state_d      = S_PUSH;
            pix_cnt_d    = '0;
            pix_ready_d  = 1'b0;
            row_load_L_d = 1'b0;
            row_out_d    = asm_row;
            row_idx_d    = row_cnt_q;
          end else begin
            pix_cnt_d = pix_cnt_q + 4'd1;
          end
        end
      end
      S_PUSH: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d      = S_DONE;
          block_done_d = 1'b1;
        end else begin
          state_d     = S_FILL;
          row_cnt_d   = row_cnt_q + 4'd1;
          pix_ready_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pix_ready_q  <= 1'b0;
      row_out_q    <= '0;
      row_load_L_q <= 1'b1;
      row_idx_q    <= '0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pix_ready_q  <= pix_ready_d;
      row_out_q    <= row_out_d;
      row_load_L_q <= row_load_L_d;
      row_idx_q    <= row_idx_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign row_out    = row_out_q;
  assign row_load_L = row_load_L_q;
  assign row_idx    = row_idx_q;
  assign busy       = busy_q;
  assign block_done = block_done_q;
endmodule

// File: tb/tb_ref_block_packer.sv
// Directed bench for ref_block_packer: single-row vector table, full blocks with
// and without gaps, start-while-busy, back-to-back blocks and mid-block reset.

module tb_ref_block_packer;
  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 15;
  localparam int ROWS    = 15;
  localparam int RW      = ROW_PIX * PIX_W;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [RW-1:0] row_out;
  logic          row_load_L;
  logic [3:0]    row_idx;
  logic          busy;
  logic          block_done;

  ref_block_packer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .row_out(row_out),
    .row_load_L(row_load_L), .row_idx(row_idx), .busy(busy), .block_done(block_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // strobe / done / idle monitor, sampled on the consumer edge
  logic [RW-1:0] st_row[$];
  int            st_idx[$];
  int            st_cyc[$];
  bit            st_pr[$];
  int            done_cyc[$];
  int            idle_cyc = -1;
  int            stray = 0;
  logic [RW-1:0] last_row = '0;
  logic          busy_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset_L) last_row = '0;
    else begin
      if (!row_load_L) begin
        st_row.push_back(row_out);
        st_idx.push_back(int'(row_idx));
        st_cyc.push_back(cyc);
        st_pr.push_back(pix_ready);
        last_row = row_out;
      end else if (row_out !== last_row) stray++;
      if (block_done) done_cyc.push_back(cyc);
      if (busy_prev && !busy) idle_cyc = cyc;
    end
    busy_prev = busy;
  end

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    st_row.delete(); st_idx.delete(); st_cyc.delete(); st_pr.delete(); done_cyc.delete();
    idle_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0; start = 1'b0; pix_valid = 1'b0;
    @(negedge clock); #1;
    reset_L = 1'b1;
    tick();
    clr();
  endtask

  task automatic do_start(output int e0);
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
  endtask

  // Present one pixel after 'gap' idle cycles; returns after the accepting edge.
  task automatic feed_pixel(input logic [7:0] v, input int gap);
    bit acc = 1'b0;
    pix_valid = 1'b0;
    repeat (gap) tick();
    pix_valid = 1'b1;
    pix_in = v;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = pix_ready;
      tick();
    end
    pix_valid = 1'b0;
    if (!acc) chk(1'b0, "feed_timeout", 128'(v), 128'(v));
  endtask

  function automatic logic [7:0] pix_val(input int pat, input int r, input int c);
    int v = r * 16 + c;
    return (pat == 0) ? 8'(v) : 8'(255 - v);
  endfunction

  function automatic logic [RW-1:0] exp_row(input int pat, input int r);
    logic [RW-1:0] w = '0;
    for (int c = 0; c < ROW_PIX; c++) w[c*PIX_W +: PIX_W] = pix_val(pat, r, c);
    return w;
  endfunction

  task automatic feed_block(input int pat, input int max_gap);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < ROW_PIX; c++)
        feed_pixel(pix_val(pat, r, c), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && idle_cyc < 0; i++) tick();
  endtask

  task automatic check_block(input string nm, input int pat, input int e0, input bit timed);
    int n = st_row.size();
    bit pr_bad = 1'b0;
    chk(n == ROWS, {nm, "_nrows"}, 128'(n), 128'(ROWS));
    for (int r = 0; r < n && r < ROWS; r++) begin
      chk(st_row[r] === exp_row(pat, r), {nm, "_row", $sformatf("%0d", r)}, 128'(st_row[r]), 128'(exp_row(pat, r)));
      chk(st_idx[r] == r, {nm, "_idx"}, 128'(st_idx[r]), 128'(r));
      if (timed) chk(st_cyc[r] == e0 + 15 + 16 * r, {nm, "_strobe_cyc"}, 128'(st_cyc[r] - e0), 128'(15 + 16 * r));
      if (st_pr[r]) pr_bad = 1'b1;
    end
    chk(!pr_bad, {nm, "_ready_in_push"}, 128'(pr_bad), 128'(0));
    if (done_cyc.size() == 1 && n > 0)
      chk(done_cyc[0] == st_cyc[n-1] + 1, {nm, "_done_lat"}, 128'(done_cyc[0] - st_cyc[n-1]), 128'(1));
    else chk(1'b0, {nm, "_done_count"}, 128'(done_cyc.size()), 128'(1));
    if (timed) chk(idle_cyc - e0 == 241, {nm, "_block_cycles"}, 128'(idle_cyc - e0), 128'(241));
  endtask

  typedef struct {
    string         name;
    logic [7:0]    base;
    logic [7:0]    step;
    logic [RW-1:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int e0, e1;
    vecs[0] = '{"row_ramp",  8'h01, 8'h01, 120'h0F0E0D0C0B0A090807060504030201};
    vecs[1] = '{"row_ones",  8'hFF, 8'h00, 120'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF};
    vecs[2] = '{"row_wrap",  8'hF8, 8'h01, 120'h06050403020100FFFEFDFCFBFAF9F8};
    vecs[3] = '{"row_step",  8'h80, 8'h10, 120'h60504030201000F0E0D0C0B0A09080};
    vecs[4] = '{"row_const", 8'hA5, 8'h00, 120'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5};

    // reset state
    #12;
    chk(pix_ready == 0 && row_load_L == 1 && busy == 0 && block_done == 0, "reset_ctrl",
        {pix_ready, row_load_L, busy, block_done}, 4'b0100);
    chk(row_out == '0 && row_idx == 0, "reset_data", 128'(row_out), 128'(0));
    do_reset();

    // mid-FILL reset aborts without a strobe
    do_start(e0);
    for (int k = 0; k < 7; k++) feed_pixel(8'(k + 1), 0);
    #2 reset_L = 1'b0;
    #1;
    chk(row_load_L == 1 && pix_ready == 0 && busy == 0, "t1_async_ctrl",
        {row_load_L, pix_ready, busy}, 3'b100);
    chk(row_out == '0, "t1_row_out", 128'(row_out), 128'(0));
    @(negedge clock); #1 reset_L = 1'b1;
    pix_valid = 1'b1;
    repeat (30) tick();
    pix_valid = 1'b0;
    chk(st_row.size() == 0 && pix_ready == 0 && busy == 0, "t1_no_strobe",
        128'(st_row.size()), 128'(0));
    clr();

    // single-row vector table
    foreach (vecs[i]) begin
      do_reset();
      do_start(e0);
      for (int k = 0; k < ROW_PIX; k++) feed_pixel(vecs[i].base + 8'(k) * vecs[i].step, 0);
      tick();
      chk(st_row.size() == 1, {vecs[i].name, "_nstrobe"}, 128'(st_row.size()), 128'(1));
      if (st_row.size() > 0) begin
        chk(st_row[0] === vecs[i].exp, vecs[i].name, 128'(st_row[0]), 128'(vecs[i].exp));
        chk(st_idx[0] == 0 && st_pr[0] == 0, {vecs[i].name, "_idx_ready"},
            128'({st_idx[0], 3'b0, st_pr[0]}), 128'(0));
        chk(st_cyc[0] == e0 + 15, {vecs[i].name, "_lat"}, 128'(st_cyc[0] - e0), 128'(15));
      end
    end

    // full block, continuous
    do_reset();
    do_start(e0);
    feed_block(0, 0);
    wait_idle();
    check_block("t3", 0, e0, 1'b1);

    // full block with gaps
    clr();
    do_start(e0);
    feed_block(0, 5);
    wait_idle();
    check_block("t4", 0, e0, 1'b0);

    // start pulses during row 3 and in DONE, then back-to-back block
    clr();
    do_start(e0);
    fork
      feed_block(0, 0);
      begin
        for (int i = 0; i < 300 && st_cyc.size() < 3; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && !block_done; i++) tick();
        start = 1'b1;
        tick();
      end
    join
    chk(busy == 0 && pix_ready == 0, "t5_no_restart", {busy, pix_ready}, 2'b00);
    tick();
    start = 1'b0;
    e1 = cyc;
    chk(busy == 1 && pix_ready == 1, "t6_accept", {busy, pix_ready}, 2'b11);
    check_block("t5", 0, e0, 1'b1);
    clr();
    feed_block(1, 0);
    wait_idle();
    check_block("t6", 1, e1, 1'b1);

    chk(stray == 0, "row_out_stable", 128'(stray), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
